// File: rtl/downstream_pkg.sv
// Shared types for the downstream write controller.
// State encoding for the request/acknowledge sequencer and a pointer-width helper.
// No logic; imported by the arbiter and the controller top.
package downstream_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_LOW = 2'd2
    } ds_state_t;

    // Width of a channel index / round-robin pointer for n channels.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/downstream_wr_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first requester strictly after ptr, wrapping.
// Latency: purely combinational, no state (the caller owns the pointer).
// Backpressure: none; gnt_valid is low when no request bit is set.
// Ports: req[N] request vector, ptr last granted index,
//        gnt_idx winning index, gnt_valid any request present.
module rr_arbiter
    import downstream_pkg::*;
#(
    parameter int N = 4,
    localparam int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [PW-1:0] cand;

    // Walk offsets from lowest to highest priority so the nearest requester
    // after ptr overwrites any farther one; offset N is ptr itself (last).
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int off = N; off >= 1; off--) begin
            cand = PW'((int'(ptr) + off) % N);
            if (req[cand]) begin
                gnt_idx   = cand;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/downstream_wr_ctrl.sv
// Multi-channel write-back sequencer: round-robin grant, one 4-phase req/ack to memory.
// Latency: mem_req rises 1 cycle after a request is seen; min transaction 4 cycles.
// Backpressure: requests wait in IDLE until the current handshake completes; ack timeout aborts.
// Ports: clk/rst_n (sync, active-low); ch_memwr/ch_addr/ch_data per-channel requests;
//        ch_done/ch_err per-channel completion pulses; mem_req/mem_addr/mem_data/mem_ack
//        memory handshake; busy high whenever not IDLE.
module downstream_wr_ctrl
    import downstream_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_memwr,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        ch_err,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_data,
    input  logic                     mem_ack,
    output logic                     busy
);

    localparam int PW = ptr_w(NUM_CH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
    localparam logic [PW-1:0] PTR_RST = PW'(NUM_CH - 1);

    ds_state_t           state_q, state_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]       grant_q, grant_d;
    logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                err_flag_q, err_flag_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;
    logic [NUM_CH-1:0]   ch_done_q, ch_done_d;
    logic [NUM_CH-1:0]   ch_err_q, ch_err_d;

    logic [ADDR_W-1:0]   addr_arr [NUM_CH];
    logic [DATA_W-1:0]   data_arr [NUM_CH];
    logic [PW-1:0]       arb_idx;
    logic                arb_vld;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            addr_arr[i] = ch_addr[i*ADDR_W +: ADDR_W];
            data_arr[i] = ch_data[i*DATA_W +: DATA_W];
        end
    end

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .req       (ch_memwr),
        .ptr       (rr_ptr_q),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_vld)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        tmo_cnt_d  = tmo_cnt_q;
        err_flag_d = err_flag_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        ch_done_d  = '0;
        ch_err_d   = '0;

        case (state_q)
            IDLE: begin
                // mem_ack is deliberately ignored here.
                if (arb_vld) begin
                    state_d    = REQ;
                    grant_d    = arb_idx;
                    rr_ptr_d   = arb_idx;
                    mem_addr_d = addr_arr[arb_idx];
                    mem_data_d = data_arr[arb_idx];
                    mem_req_d  = 1'b1;
                    tmo_cnt_d  = TW'(1);
                end
            end
            REQ: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (mem_ack) begin
                    state_d    = WAIT_LOW;
                    mem_req_d  = 1'b0;
                    err_flag_d = 1'b0;
                end else if (tmo_cnt_q == TMO_MAX) begin
                    state_d    = WAIT_LOW;
                    mem_req_d  = 1'b0;
                    err_flag_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            WAIT_LOW: begin
                // No timeout: the memory must release ack before we return.
                if (!mem_ack) begin
                    state_d = IDLE;
                    if (err_flag_q) ch_err_d[grant_q]  = 1'b1;
                    else            ch_done_d[grant_q] = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= PTR_RST;
            grant_q    <= '0;
            tmo_cnt_q  <= '0;
            err_flag_q <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            ch_done_q  <= '0;
            ch_err_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            tmo_cnt_q  <= tmo_cnt_d;
            err_flag_q <= err_flag_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            ch_done_q  <= ch_done_d;
            ch_err_q   <= ch_err_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign ch_done  = ch_done_q;
    assign ch_err   = ch_err_q;
    assign busy     = (state_q != IDLE);

endmodule
